// File: rtl/grid_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// grid_mem_arbiter_pkg: shared constants and types for the placement RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package grid_mem_arbiter_pkg;

  localparam int GRID_N         = 9;
  localparam int DEFAULT_DATA_W = 32;
  localparam int TAG_IDX_W      = 2;

  localparam logic signed [31:0] EMPTY_CELL = -32'sd1;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic                 oor;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

  function automatic logic addr_in_range(input logic signed [31:0] a, input int depth);
    return (a >= 0) && (a < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_mem_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// grid_mem_arbiter_rr_pick: combinational round-robin picker starting at rr_ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module grid_mem_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] cand;
  logic [IW:0]  pos;

  assign cand = req & mask;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      // rr_ptr + i wrapped into 0..N-1 without a divider
      pos = {1'b0, rr_ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && cand[pos[IW-1:0]]) begin
        found              = 1'b1;
        idx                = pos[IW-1:0];
        gnt[pos[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/grid_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// grid_mem_arbiter: lockable round-robin arbiter sharing one placement RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module grid_mem_arbiter
  import grid_mem_arbiter_pkg::*;
#(
  parameter int                N_REQ    = 2,
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter int                DEPTH    = 81,
  parameter int                RD_LAT   = 1,
  parameter int                LOCK_MAX = 64,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*32-1:0]       addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      lock_err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [0:0]         state, state_nxt;
  logic [IW-1:0]      owner, owner_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]      lock_cnt, lock_cnt_nxt;

  logic [N_REQ-1:0]   pick_mask, pick_gnt;
  logic [IW-1:0]      win_idx;
  logic               pick_found, win_valid;

  logic signed [31:0] addr_a  [N_REQ];
  logic [DATA_W-1:0]  wdata_a [N_REQ];
  logic signed [31:0] win_addr;
  logic               win_in_range;

  rd_tag_t            tag_in;
  rd_tag_t            tag_q [RD_LAT+1];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[32*g +: 32];
    assign wdata_a[g] = wdata[DATA_W*g +: DATA_W];
  end

  // While locked only the owner is eligible
  assign pick_mask = (state == ARB_LOCKED) ? (N_REQ'(1) << owner) : '1;

  grid_mem_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mask   (pick_mask),
    .gnt    (pick_gnt),
    .idx    (win_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB_IDLE: begin
        if (win_valid) begin
          rr_ptr_nxt = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (lock[win_idx]) begin
            state_nxt    = ARB_LOCKED;
            owner_nxt    = win_idx;
            lock_cnt_nxt = '0;
          end
        end
      end
      ARB_LOCKED: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        if (!lock[owner] || (lock_cnt == CW'(LOCK_MAX - 1))) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt       = reset ? '0 : pick_gnt;
    win_valid = !reset && pick_found;
    lock_err  = !reset && (state == ARB_LOCKED) && lock[owner] &&
                (lock_cnt == CW'(LOCK_MAX - 1));
  end

  assign win_addr     = addr_a[win_idx];
  assign win_in_range = addr_in_range(win_addr, DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_read  <= win_valid && !we[win_idx] && win_in_range;
      mem_write <= win_valid &&  we[win_idx] && win_in_range;
      if (win_valid) begin
        mem_addr  <= win_addr;
        mem_wdata <= wdata_a[win_idx];
      end
    end
  end

  // Out-of-range reads still carry a tag so the requester gets its rvalid
  always_comb begin
    tag_in       = '0;
    tag_in.valid = win_valid && !we[win_idx];
    tag_in.oor   = !win_in_range;
    tag_in.idx   = TAG_IDX_W'(win_idx);
  end

  for (genvar s = 0; s <= RD_LAT; s++) begin : g_tag
    if (s == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) tag_q[s] <= '0;
        else       tag_q[s] <= tag_in;
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (reset) tag_q[s] <= '0;
        else       tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_q[RD_LAT].valid) begin
      rvalid = N_REQ'(1) << tag_q[RD_LAT].idx;
      rdata  = tag_q[RD_LAT].oor ? OOR_DATA : mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_grid_mem_arbiter: directed stimulus, cycle model of arbitration and RAM contents
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grid_mem_arbiter;
  import grid_mem_arbiter_pkg::*;

  localparam int N = 2, DW = 32, DEPTH = 81, RD_LAT = 1, LOCK_MAX = 64, MAXC = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, lock, gnt, rvalid;
  logic [N*32-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            lock_err, mem_read, mem_write;
  logic [31:0]     mem_addr;

  always #5 clk = ~clk;

  grid_mem_arbiter #(
    .N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX), .OOR_DATA('0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_err(lock_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM fixture: one-cycle registered read
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  assign mem_rdata = ram_q;
  initial begin
    ram_q = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'(100 + 3 * i);
    ram[40] = EMPTY_CELL;
    forever begin
      @(posedge clk);
      if (mem_write && mem_addr < DEPTH) ram[int'(mem_addr)] <= mem_wdata;
      if (mem_read && mem_addr < DEPTH) ram_q <= ram[int'(mem_addr)];
    end
  end

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct { bit w; int a; logic [31:0] d; } op_t;
  op_t q0[$], q1[$];
  logic [N-1:0] lk, gnt_seen;

  task automatic push(input int k, input bit w, input int a, input logic [31:0] d);
    op_t o;
    o.w = w; o.a = a; o.d = d;
    if (k == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  // Requester behaviour: hold req until granted, then move to the next queued op
  always @(negedge clk) gnt_seen <= gnt;
  initial begin
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (gnt_seen[0] && q0.size() > 0) void'(q0.pop_front());
      if (gnt_seen[1] && q1.size() > 0) void'(q1.pop_front());
      req[0] = q0.size() > 0;
      req[1] = q1.size() > 0;
      if (q0.size() > 0) begin we[0] = q0[0].w; addr[31:0] = q0[0].a; wdata[31:0] = q0[0].d; end
      else we[0] = 1'b0;
      if (q1.size() > 0) begin we[1] = q1[0].w; addr[63:32] = q1[0].a; wdata[63:32] = q1[0].d; end
      else we[1] = 1'b0;
      lock = lk;
    end
  end

  // Behavioural model: owner/-1, rr pointer, cycles held; expected events scheduled by cycle
  logic [31:0] shadow [DEPTH];
  bit          exp_rd [MAXC], exp_wr [MAXC];
  bit [31:0]   exp_ad [MAXC], exp_wd [MAXC], exp_rdat [MAXC];
  bit [1:0]    exp_rv [MAXC];
  logic [1:0]  glog [MAXC];
  int          m_owner = -1, m_rr = 0, m_held = 0;
  int          win, nown, nheld, a;
  bit          inr, err_exp;
  logic [1:0]  g_exp;
  logic [31:0] cap0[$], cap1[$];
  int          fg0 = -1, fg1 = -1, ferr = -1, n_gnt = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'(100 + 3 * i);
    shadow[40] = EMPTY_CELL;
  end

  always @(negedge clk) begin
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    win = -1; err_exp = 1'b0; g_exp = '0;
    if (reset) begin
      m_owner = -1; m_rr = 0; m_held = 0;
      for (int c = cyc + 1; c < MAXC; c++) begin exp_rd[c] = 0; exp_wr[c] = 0; exp_rv[c] = 0; end
    end else begin
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) if (win < 0 && req[(m_rr + i) % N]) win = (m_rr + i) % N;
      end else if (req[m_owner]) win = m_owner;
      if (win >= 0) g_exp = 2'(1 << win);
      nown = m_owner; nheld = m_held + 1;
      if (m_owner >= 0) begin
        if (!lock[m_owner]) nown = -1;
        else if (m_held == LOCK_MAX - 1) begin nown = -1; err_exp = 1'b1; end
      end else if (win >= 0) begin
        m_rr = (win + 1) % N;
        if (lock[win]) begin nown = win; nheld = 0; end
      end
      if (win >= 0) begin
        a   = $signed(addr[32*win +: 32]);
        inr = (a >= 0) && (a < DEPTH);
        exp_rd[cyc+1] = !we[win] && inr;
        exp_wr[cyc+1] = we[win] && inr;
        exp_ad[cyc+1] = a;
        exp_wd[cyc+1] = wdata[32*win +: 32];
        if (we[win]) begin
          if (inr) shadow[a] = wdata[32*win +: 32];
        end else begin
          exp_rv[cyc+1+RD_LAT]   = 2'(1 << win);
          exp_rdat[cyc+1+RD_LAT] = inr ? shadow[a] : 32'd0;
        end
      end
      m_owner = nown; m_held = nheld;
    end
    check("gnt", gnt, g_exp);
    check("lock_err", lock_err, err_exp);
    check("mem_read", mem_read, exp_rd[cyc]);
    check("mem_write", mem_write, exp_wr[cyc]);
    if (exp_rd[cyc] || exp_wr[cyc]) check("mem_addr", mem_addr, exp_ad[cyc]);
    if (exp_wr[cyc]) check("mem_wdata", mem_wdata, exp_wd[cyc]);
    check("rvalid", rvalid, exp_rv[cyc]);
    if (exp_rv[cyc] != 0) check("rdata", rdata, exp_rdat[cyc]);
    glog[cyc] = gnt;
    if (gnt != 0) n_gnt++;
    if (rvalid[0]) cap0.push_back(rdata);
    if (rvalid[1]) cap1.push_back(rdata);
    if (gnt[0] && fg0 < 0) fg0 = cyc;
    if (gnt[1] && fg1 < 0) fg1 = cyc;
    if (lock_err && ferr < 0) ferr = cyc;
  end

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  int t0;
  initial begin
    reset = 1'b1; lk = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (12) @(negedge clk);
    check("idle_no_grants", n_gnt, 0);

    // Both requesters reading: strict alternation
    push(0, 0, 5, 0); push(0, 0, 5, 0); push(1, 0, 6, 0); push(1, 0, 6, 0);
    t0 = cyc;
    repeat (8) @(negedge clk);
    check("rr_gnt0", glog[t0+1], 2'b01); check("rr_gnt1", glog[t0+2], 2'b10);
    check("rr_gnt2", glog[t0+3], 2'b01); check("rr_gnt3", glog[t0+4], 2'b10);
    check("rr_r0_n", cap0.size(), 2); check("rr_r0_d", at(cap0, 1), 115);
    check("rr_r1_n", cap1.size(), 2); check("rr_r1_d", at(cap1, 0), 118);

    // Locked check-then-write by R0 while R1 waits on the same cell
    cap0.delete(); cap1.delete(); fg1 = -1;
    lk[0] = 1'b1; push(0, 0, 40, 0); push(0, 1, 40, 7); push(1, 0, 40, 0);
    t0 = cyc;
    repeat (4) @(negedge clk);
    lk[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("lock_r1_gnt_cycle", fg1 - t0, 6);
    check("lock_r0_empty", at(cap0, 0), 32'hFFFF_FFFF);
    check("lock_r1_sees_7", at(cap1, 0), 7);

    // Lock held past LOCK_MAX with R0 waiting
    cap0.delete(); cap1.delete(); fg0 = -1; fg1 = -1; ferr = -1;
    lk[1] = 1'b1; push(1, 0, 10, 0);
    t0 = cyc;
    @(negedge clk);
    push(0, 0, 11, 0);
    repeat (70) @(negedge clk);
    lk[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("to_r1_gnt", fg1 - t0, 1);
    check("to_err_cycle", ferr - t0, 65);
    check("to_r0_gnt", fg0 - t0, 66);
    check("to_r0_data", at(cap0, 0), 133);
    check("to_r1_data", at(cap1, 0), 130);

    // Out-of-range accesses
    cap0.delete();
    push(0, 0, -1, 0); push(0, 0, 81, 0); push(0, 1, 81, 55);
    repeat (7) @(negedge clk);
    check("oor_n", cap0.size(), 2);
    check("oor_d0", at(cap0, 0), 0); check("oor_d1", at(cap0, 1), 0);

    // Write then read same cell on consecutive grants
    cap1.delete();
    push(0, 1, 20, 32'hFFFF_FFFB);
    @(negedge clk);
    push(1, 0, 20, 0);
    repeat (6) @(negedge clk);
    check("wf_data", at(cap1, 0), 32'hFFFF_FFFB);

    // Reset the cycle after a read grant
    cap0.delete();
    push(0, 0, 3, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_rvalid", cap0.size(), 0);
    fg0 = -1; fg1 = -1;
    push(0, 0, 7, 0); push(1, 0, 8, 0);
    t0 = cyc;
    repeat (6) @(negedge clk);
    check("rst_rr_r0_first", fg0 - t0, 1);
    check("rst_rr_r1_second", fg1 - t0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
